// File: rtl/imm_extend_unit.sv
// imm_extend_unit: pipelined immediate extender (SIGN/ZERO/UPPER/BRANCH) behind a valid/ready
// handshake with an output register plus one skid entry. Define IMM_EXT_CNT_EN to add the
// saturating cnt_total/cnt_neg output-handshake counters.
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_neg
`endif
);

    localparam int E = OUT_W - IN_W;
    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;

    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_unit: OUT_W must be at least IN_W+2");
    end
    if (CNT_W < 1) begin : g_cnt_check
        $error("imm_extend_unit: CNT_W must be at least 1");
    end

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_neg_q, out_neg_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_neg_q, skid_neg_d;
    logic [OUT_W-1:0] sign_ext, ext_data;
    logic             in_fire, out_free;

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_neg   = out_neg_q;
    assign in_fire   = in_valid && in_ready;
    assign out_free  = !out_valid_q || out_ready;

    // Extend the incoming immediate according to its mode before it is registered
    always_comb begin
        sign_ext = {{E{in_imm[IN_W-1]}}, in_imm};
        ext_data = in_mode == MODE_SIGN  ? sign_ext :
                   in_mode == MODE_ZERO  ? {{E{1'b0}}, in_imm} :
                   in_mode == MODE_UPPER ? {in_imm, {E{1'b0}}} :
                                           {sign_ext[OUT_W-3:0], 2'b00};
    end

    // Output register refills from the skid entry first so FIFO order is kept; new items
    // land in the output register when it frees up, otherwise in the skid entry
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_neg_d    = out_neg_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_neg_d   = skid_neg_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                out_neg_d    = skid_neg_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_data;
                out_tag_d   = in_tag;
                out_neg_d   = in_imm[IN_W-1];
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_data;
            skid_tag_d   = in_tag;
            skid_neg_d   = in_imm[IN_W-1];
        end
    end

    // Pipeline state; reset empties both entries and clears the visible output
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_neg_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            skid_neg_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_neg_q    <= out_neg_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_neg_q   <= skid_neg_d;
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [CNT_W-1:0] cnt_total_q, cnt_total_d, cnt_neg_q, cnt_neg_d;
    logic             out_fire;

    assign out_fire  = out_valid_q && out_ready;
    assign cnt_total = cnt_total_q;
    assign cnt_neg   = cnt_neg_q;

    // Saturating counts of output handshakes, total and negative-immediate
    always_comb begin
        cnt_total_d = (out_fire && cnt_total_q != '1) ? cnt_total_q + CNT_W'(1) : cnt_total_q;
        cnt_neg_d   = (out_fire && out_neg_q && cnt_neg_q != '1) ? cnt_neg_q + CNT_W'(1) : cnt_neg_q;
    end

    // Counter state, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_total_q <= '0;
            cnt_neg_q   <= '0;
        end else begin
            cnt_total_q <= cnt_total_d;
            cnt_neg_q   <= cnt_neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed and randomized checks of imm_extend_unit against a queue model
module tb_imm_extend_unit;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, out_neg;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_data;
`ifdef IMM_EXT_CNT_EN
    logic [15:0] cnt_total, cnt_neg;
    int          tot_model = 0, neg_model = 0;
`endif

    int checks = 0, failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        logic        n;
    } item_t;
    item_t q[$];

    imm_extend_unit #(.IN_W(16), .OUT_W(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_neg(out_neg)
`ifdef IMM_EXT_CNT_EN
        , .cnt_total(cnt_total), .cnt_neg(cnt_neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference extension from plain integer arithmetic
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
        int sv;
        sv = int'($signed(imm));
        if (m == 2'd0) return 32'(sv);
        if (m == 2'd1) return 32'(imm);
        if (m == 2'd2) return 32'(imm) * 32'd65536;
        return 32'(sv * 4);
    endfunction

    // One clock: check the visible state against the model, apply handshakes, advance
    task automatic cyc();
        bit    inf, outf;
        item_t it;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        chk("out_valid_occ", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready_occ", 32'(in_ready), 32'(q.size() < 2));
        if (out_valid && q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_tag", 32'(out_tag), 32'(q[0].t));
            chk("out_neg", 32'(out_neg), 32'(q[0].n));
        end
        if (outf && q.size() > 0) begin
`ifdef IMM_EXT_CNT_EN
            if (tot_model < 65535) tot_model++;
            if (out_neg && neg_model < 65535) neg_model++;
`endif
            void'(q.pop_front());
        end
        if (inf) begin
            it.d = ref_ext(in_imm, in_mode);
            it.t = in_tag;
            it.n = in_imm[15];
            q.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] m, input logic [4:0] t);
        in_valid = v;
        in_imm   = imm;
        in_mode  = m;
        in_tag   = t;
    endtask

    logic [15:0] v_imm[6]  = '{16'hFFF6, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h7FFF};
    logic [1:0]  v_mode[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] v_exp[6]  = '{32'hFFFFFFF6, 32'h00007FFF, 32'h00008000, 32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};
    logic        v_neg[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_neg", 32'(out_neg), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, v_imm[i], v_mode[i], 5'(i));
            cyc();
            drive(1'b0, 16'h0, 2'd0, 5'd0);
            chk("mode_valid", 32'(out_valid), 32'd1);
            chk("mode_data", out_data, v_exp[i]);
            chk("mode_neg", 32'(out_neg), 32'(v_neg[i]));
            cyc();
        end
        chk("mode_drained_valid", 32'(out_valid), 32'd0);
        chk("mode_hold_data", out_data, v_exp[5]);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i * 300), 2'd0, 5'(i));
            cyc();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_tag", 32'(out_tag), 32'(i));
        end
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        cyc();

        out_ready = 1'b0;
        drive(1'b1, 16'h8001, 2'd0, 5'd1);
        cyc();
        chk("bp_hold_a", 32'(out_tag), 32'd1);
        chk("bp_ready_a", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h0042, 2'd1, 5'd2);
        cyc();
        chk("bp_ready_b", 32'(in_ready), 32'd0);
        chk("bp_hold_a2", 32'(out_tag), 32'd1);
        drive(1'b1, 16'h00C3, 2'd3, 5'd3);
        cyc();
        chk("bp_ignore_c", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("sim_b_out", 32'(out_tag), 32'd2);
        chk("sim_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("sim_c_out", 32'(out_tag), 32'd3);
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        cyc();
        chk("sim_empty", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 2'd0, 5'd10);
        cyc();
        drive(1'b1, 16'h2222, 2'd0, 5'd11);
        cyc();
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
`ifdef IMM_EXT_CNT_EN
        tot_model = 0;
        neg_model = 0;
`endif
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) cyc();

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) < 6), 16'($urandom), 2'($urandom), 5'($urandom));
            out_ready = 1'($urandom_range(0, 9) < 6);
            cyc();
        end
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_empty", 32'(q.size()), 32'd0);
`ifdef IMM_EXT_CNT_EN
        chk("cnt_total", 32'(cnt_total), 32'(tot_model));
        chk("cnt_neg", 32'(cnt_neg), 32'(neg_model));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
